// File: rtl/pc_sequencer.sv
// ---------------------------------------------------------------------------
// pc_sequencer
//
// Program-counter and return-address sequencer. It owns the fetch address
// and keeps an on-chip return-address stack for CALL/RET.
//
// Per-cycle priority while running:
//   stall > RET > CALL > jump > sequential increment.
// A RET with an empty stack, or a CALL with a full stack, holds the PC,
// sets a sticky error flag and parks the sequencer in HALT. HALT is left
// only through i_Reset.
//
// Ports:
//   i_Clk                     system clock, rising edge
//   i_Reset                   synchronous, active-high reset
//   i_Jump_Valid              jump unit reports branch taken this cycle
//   i_Jump_Target             branch/call target address
//   i_Call                    CALL in execute (target from i_Jump_Target)
//   i_Ret                     RET in execute
//   i_Stall                   hold PC and stack this cycle
//   o_Addressinstruction_Bus  registered fetch address
//   o_Stack_Depth             number of valid stack entries, 0..DEPTH
//   o_Overflow                sticky: CALL attempted with a full stack
//   o_Underflow               sticky: RET attempted with an empty stack
//   o_Halted                  sequencer is in HALT
// ---------------------------------------------------------------------------
module pc_sequencer #(
    parameter int                 ADDR_W     = 9,
    parameter int                 DEPTH      = 8,
    parameter logic [ADDR_W-1:0]  RESET_ADDR = 9'd0
) (
    input  logic                       i_Clk,
    input  logic                       i_Reset,
    input  logic                       i_Jump_Valid,
    input  logic [ADDR_W-1:0]          i_Jump_Target,
    input  logic                       i_Call,
    input  logic                       i_Ret,
    input  logic                       i_Stall,
    output logic [ADDR_W-1:0]          o_Addressinstruction_Bus,
    output logic [$clog2(DEPTH):0]     o_Stack_Depth,
    output logic                       o_Overflow,
    output logic                       o_Underflow,
    output logic                       o_Halted
);

    localparam int PTR_W   = $clog2(DEPTH);
    localparam int DEPTH_W = PTR_W + 1;

    typedef enum logic [0:0] {
        ST_RUN  = 1'b0,
        ST_HALT = 1'b1
    } state_t;

    // Registered state
    state_t                 state_r;
    logic [ADDR_W-1:0]      pc_r;
    logic [DEPTH_W-1:0]     depth_r;
    logic                   ovf_r;
    logic                   unf_r;
    logic [ADDR_W-1:0]      stack_r [DEPTH];

    // Next-state values
    state_t                 state_nx_s;
    logic [ADDR_W-1:0]      pc_nx_s;
    logic [DEPTH_W-1:0]     depth_nx_s;
    logic                   ovf_nx_s;
    logic                   unf_nx_s;

    // Stack write port
    logic                   push_s;
    logic [PTR_W-1:0]       push_idx_s;
    logic [ADDR_W-1:0]      push_data_s;

    // Helpers
    logic [ADDR_W-1:0]      pc_inc_s;
    logic [PTR_W-1:0]       pop_idx_s;
    logic                   stack_empty_s;
    logic                   stack_full_s;

    // PC+1 wraps naturally at the address width; this is also the pushed
    // return address, so a CALL at the top address returns to zero.
    assign pc_inc_s      = pc_r + ADDR_W'(1);
    assign pop_idx_s     = PTR_W'(depth_r - DEPTH_W'(1));
    assign push_idx_s    = PTR_W'(depth_r);
    assign push_data_s   = pc_inc_s;
    assign stack_empty_s = (depth_r == DEPTH_W'(0));
    assign stack_full_s  = (depth_r == DEPTH_W'(DEPTH));

    // Next-state / next-PC / stack-push decision for the two-state sequencer
    always_comb begin
        state_nx_s = state_r;
        pc_nx_s    = pc_r;
        depth_nx_s = depth_r;
        ovf_nx_s   = ovf_r;
        unf_nx_s   = unf_r;
        push_s     = 1'b0;

        case (state_r)
            ST_RUN: begin
                if (i_Stall) begin
                    // Everything holds; strobes are ignored.
                    pc_nx_s = pc_r;
                end else if (i_Ret) begin
                    // RET wins over a simultaneous CALL; the CALL is dropped.
                    if (!stack_empty_s) begin
                        pc_nx_s    = stack_r[pop_idx_s];
                        depth_nx_s = depth_r - DEPTH_W'(1);
                    end else begin
                        unf_nx_s   = 1'b1;
                        state_nx_s = ST_HALT;
                    end
                end else if (i_Call) begin
                    if (!stack_full_s) begin
                        push_s     = 1'b1;
                        pc_nx_s    = i_Jump_Target;
                        depth_nx_s = depth_r + DEPTH_W'(1);
                    end else begin
                        ovf_nx_s   = 1'b1;
                        state_nx_s = ST_HALT;
                    end
                end else if (i_Jump_Valid) begin
                    pc_nx_s = i_Jump_Target;
                end else begin
                    pc_nx_s = pc_inc_s;
                end
            end

            ST_HALT: begin
                // Frozen until reset.
                state_nx_s = ST_HALT;
            end

            default: begin
                // Unreachable encoding: park safely.
                state_nx_s = ST_HALT;
            end
        endcase
    end

    // State, PC, depth and sticky flag registers with synchronous reset
    always_ff @(posedge i_Clk) begin
        if (i_Reset) begin
            state_r <= ST_RUN;
            pc_r    <= RESET_ADDR;
            depth_r <= DEPTH_W'(0);
            ovf_r   <= 1'b0;
            unf_r   <= 1'b0;
        end else begin
            state_r <= state_nx_s;
            pc_r    <= pc_nx_s;
            depth_r <= depth_nx_s;
            ovf_r   <= ovf_nx_s;
            unf_r   <= unf_nx_s;
        end
    end

    // Return-address storage; contents are not reset, only the depth is.
    // A push is written at the edge, so a RET on the very next cycle reads
    // the new entry straight from the array without any bypass.
    always_ff @(posedge i_Clk) begin
        if (!i_Reset && push_s) begin
            stack_r[push_idx_s] <= push_data_s;
        end
    end

    assign o_Addressinstruction_Bus = pc_r;
    assign o_Stack_Depth            = depth_r;
    assign o_Overflow               = ovf_r;
    assign o_Underflow              = unf_r;
    assign o_Halted                 = (state_r == ST_HALT);

endmodule

// File: tb/tb_pc_sequencer.sv
// ---------------------------------------------------------------------------
// tb_pc_sequencer
//
// Self-checking bench for pc_sequencer. A behavioural model (integer PC,
// queue as the return stack) is stepped alongside the DUT; every output is
// compared after each clock. Directed scenarios are followed by a random run.
// ---------------------------------------------------------------------------
module tb_pc_sequencer;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       jv = 1'b0;
    logic [8:0] tgt = 9'd0;
    logic       call = 1'b0;
    logic       ret = 1'b0;
    logic       stall = 1'b0;
    logic [8:0] bus;
    logic [3:0] depth;
    logic       ovf;
    logic       unf;
    logic       halted;

    int total = 0;
    int bad   = 0;

    // Reference model state
    int m_pc = 0;
    int m_stack[$];
    int m_ovf = 0;
    int m_unf = 0;
    int m_halt = 0;

    pc_sequencer dut (
        .i_Clk                    (clk),
        .i_Reset                  (rst),
        .i_Jump_Valid             (jv),
        .i_Jump_Target            (tgt),
        .i_Call                   (call),
        .i_Ret                    (ret),
        .i_Stall                  (stall),
        .o_Addressinstruction_Bus (bus),
        .o_Stack_Depth            (depth),
        .o_Overflow               (ovf),
        .o_Underflow              (unf),
        .o_Halted                 (halted)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input int obs, input int exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", tag, obs, obs, exp, exp);
        end
    endtask

    task automatic model_step(input bit r, input bit s, input bit rt, input bit c,
                              input bit j, input int t);
        if (r) begin
            m_pc = 0; m_stack.delete(); m_ovf = 0; m_unf = 0; m_halt = 0;
        end else if (m_halt != 0 || s) begin
            // frozen
        end else if (rt) begin
            if (m_stack.size() > 0) m_pc = m_stack.pop_back();
            else begin m_unf = 1; m_halt = 1; end
        end else if (c) begin
            if (m_stack.size() < 8) begin
                m_stack.push_back((m_pc + 1) % 512);
                m_pc = t;
            end else begin m_ovf = 1; m_halt = 1; end
        end else if (j) begin
            m_pc = t;
        end else begin
            m_pc = (m_pc + 1) % 512;
        end
    endtask

    // One clock: drive, clock, step model, compare all outputs.
    task automatic cyc(input bit r, input bit s, input bit rt, input bit c,
                       input bit j, input int t, input string tag);
        rst = r; stall = s; ret = rt; call = c; jv = j; tgt = 9'(t);
        @(posedge clk);
        model_step(r, s, rt, c, j, t);
        #1;
        chk({tag, ".bus"},   int'(bus),    m_pc);
        chk({tag, ".depth"}, int'(depth),  m_stack.size());
        chk({tag, ".ovf"},   int'(ovf),    m_ovf);
        chk({tag, ".unf"},   int'(unf),    m_unf);
        chk({tag, ".halt"},  int'(halted), m_halt);
    endtask

    task automatic idle(input string tag);
        cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 0, tag);
    endtask

    initial begin
        // Reset and free-run
        cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 0, "reset");
        chk("reset_bus_const", int'(bus), 0);
        for (int i = 0; i < 4; i++) idle("freerun");
        chk("freerun_bus_const", int'(bus), 4);
        idle("to5");

        // Jumps, including wrap at the top of the address space
        cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 'h1F0, "jump1f0");
        chk("jump_const", int'(bus), 'h1F0);
        idle("after_jump");
        chk("after_jump_const", int'(bus), 'h1F1);
        cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 'h1FF, "jump1ff");
        idle("wrap");
        chk("wrap_const", int'(bus), 0);

        // CALL / RET
        cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 'h010, "jump010");
        cyc(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 'h100, "call100");
        chk("call_depth_const", int'(depth), 1);
        idle("sub1");
        idle("sub2");
        cyc(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 0, "ret");
        chk("ret_bus_const", int'(bus), 'h011);

        // CALL at the top address returns to 0; RET right after CALL
        cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 'h1FF, "jump1ff_b");
        cyc(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 'h055, "call_at_top");
        cyc(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 0, "ret_wrap");
        chk("ret_wrap_const", int'(bus), 0);

        // Nest to full, then overflow
        for (int i = 0; i < 8; i++) cyc(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 'h20 + i, "nest");
        chk("nest_depth_const", int'(depth), 8);
        cyc(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 'h28, "overflow");
        chk("ovf_const", int'(ovf), 1);
        chk("ovf_bus_const", int'(bus), 'h27);
        for (int i = 0; i < 5; i++)
            cyc(1'b0, 1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom),
                int'($urandom_range(0, 511)), "halt_frozen");
        chk("halt_bus_const", int'(bus), 'h27);
        cyc(1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 'h1AA, "reset_from_halt");

        // Underflow from reset
        cyc(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 0, "underflow");
        chk("unf_const", int'(unf), 1);
        chk("unf_bus_const", int'(bus), 0);
        cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 0, "reset2");

        // Stall, then simultaneous CALL+RET
        cyc(1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 'h0C0, "stall_call");
        chk("stall_depth_const", int'(depth), 0);
        cyc(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 0, "stall_ret_no_unf");
        cyc(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 'h0C0, "call_c0");
        cyc(1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 'h0D0, "call_and_ret");
        chk("call_ret_bus_const", int'(bus), 1);
        chk("call_ret_depth_const", int'(depth), 0);

        // Random run
        for (int i = 0; i < 3000; i++) begin
            int p;
            bit r, s, rt, c, j;
            p  = int'($urandom_range(0, 99));
            r  = (p < 2);
            s  = ($urandom_range(0, 9) == 0);
            rt = ($urandom_range(0, 99) < 18);
            c  = ($urandom_range(0, 99) < 22);
            j  = ($urandom_range(0, 99) < 25);
            cyc(r, s, rt, c, j, int'($urandom_range(0, 511)), "rand");
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
